// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM controller user port among NREQ
// requesters with req/ack handshakes. Requester 0 always has priority. The
// others are served lowest-index first, or round-robin when
// RR_EN_DEFAULT=1. Only one controller transaction is in flight at a time.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_init_done         controller calibrated; no new grants while low
//   i_req/i_we          per-requester request and write-enable
//   i_addr/i_wdata      per-requester 32-bit address / write data (packed)
//   i_ctrl              per-requester 3-bit size/sign control (packed)
//   o_ack/o_rdata       one-cycle completion pulse and read data
//   o_gnt               one-hot current owner
//   o_err               sticky watchdog error
//   o_dram_*            controller command, address, data and ctrl
//   i_dram_rdata/busy   controller read data and busy
//
// Optional: define DRAM_ARB_WATCHDOG_EN to bound the wait on the controller
// to WD_CYCLES cycles. On expiry the transaction acks with 32'hDEAD_BEEF.
module dram_port_arbiter #(
  parameter int unsigned NREQ          = 3,
  parameter int unsigned RR_EN_DEFAULT = 0,
  parameter int unsigned WD_CYCLES     = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init_done,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_we,
  input  logic [32*NREQ-1:0]   i_addr,
  input  logic [32*NREQ-1:0]   i_wdata,
  input  logic [3*NREQ-1:0]    i_ctrl,
  output logic [NREQ-1:0]      o_ack,
  output logic [31:0]          o_rdata,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_err,
  output logic                 o_dram_rd,
  output logic                 o_dram_wr,
  output logic [31:0]          o_dram_addr,
  output logic [31:0]          o_dram_wdata,
  output logic [2:0]           o_dram_ctrl,
  input  logic [31:0]          i_dram_rdata,
  input  logic                 i_dram_busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              win_vld_c;
  logic [IW-1:0]     win_idx_c;
  logic              sel_we_c;
  logic [AW-1:0]     sel_addr_c;
  logic [DW-1:0]     sel_wdata_c;
  logic [CW-1:0]     sel_ctrl_c;
  logic              start_c;
  logic              done_c;
  logic              waiting_c;
  logic              wd_to_c;

  // Winner selection; descending loops leave the lowest qualifying index.
  always_comb begin : arb_pick
    win_vld_c = 1'b0;
    win_idx_c = '0;
    if (i_req[0]) begin
      win_vld_c = 1'b1;
    end else if (RR_EN_DEFAULT != 0) begin
      // First pass: indices at or after the pointer; second pass wraps to 1.
      for (int k = NREQ - 1; k >= 1; k--) begin
        if (i_req[k] && (k >= int'(ptr_q))) begin
          win_vld_c = 1'b1;
          win_idx_c = IW'(k);
        end
      end
      if (!win_vld_c) begin
        for (int k = NREQ - 1; k >= 1; k--) begin
          if (i_req[k]) begin
            win_vld_c = 1'b1;
            win_idx_c = IW'(k);
          end
        end
      end
    end else begin
      for (int k = NREQ - 1; k >= 1; k--) begin
        if (i_req[k]) begin
          win_vld_c = 1'b1;
          win_idx_c = IW'(k);
        end
      end
    end
  end

  // Winner's transaction fields.
  always_comb begin : sel_fields
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_ctrl_c  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx_c == IW'(k)) begin
        sel_we_c    = i_we[k];
        sel_addr_c  = i_addr[k*AW +: AW];
        sel_wdata_c = i_wdata[k*DW +: DW];
        sel_ctrl_c  = i_ctrl[k*CW +: CW];
      end
    end
  end

  assign start_c   = (state_q == S_IDLE) && i_init_done && win_vld_c && !i_dram_busy;
  assign done_c    = (state_q == S_WAIT_DONE) && !i_dram_busy;
  assign waiting_c = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);

`ifdef DRAM_ARB_WATCHDOG_EN
  localparam int unsigned WCW = $clog2(WD_CYCLES) + 1;

  logic [WCW-1:0] wd_cnt_q, wd_cnt_d;

  // Counts cycles spent waiting on the controller; fires on the last one.
  assign wd_to_c  = waiting_c && (wd_cnt_q == WCW'(WD_CYCLES - 1));
  assign wd_cnt_d = waiting_c ? (wd_cnt_q + 1'b1) : '0;

  always_ff @(posedge clk or posedge rst) begin : wd_reg
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_to_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin : fsm_reg
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a watchdog expiry overrides a late busy assertion.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start_c) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (wd_to_c)          state_d = S_ACK;
        else if (i_dram_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (done_c || wd_to_c) state_d = S_ACK;
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and pointer.
  always_comb begin : out_next
    gnt_d   = gnt_q;
    ack_d   = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    // Command strobe is set on grant so it is high exactly in ISSUE.
    if (start_c) begin
      win_d   = win_idx_c;
      gnt_d   = NREQ'(1) << win_idx_c;
      rd_d    = !sel_we_c;
      wr_d    = sel_we_c;
      addr_d  = sel_addr_c;
      wdata_d = sel_wdata_c;
      ctrl_d  = sel_ctrl_c;
    end
    if (done_c) begin
      rdata_d = i_dram_rdata;
      ack_d   = NREQ'(1) << win_q;
      gnt_d   = '0;
    end else if (wd_to_c) begin
      rdata_d = 32'hDEAD_BEEF;
      ack_d   = NREQ'(1) << win_q;
      gnt_d   = '0;
      err_d   = 1'b1;
    end
    if ((state_q == S_ACK) && (RR_EN_DEFAULT != 0)) begin
      ptr_d = (win_q == IW'(NREQ - 1)) ? IW'(1) : (win_q + 1'b1);
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin : data_reg
    if (rst) begin
      ptr_q   <= IW'(1);
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_gnt        = gnt_q;
  assign o_err        = err_q;
  assign o_dram_rd    = rd_q;
  assign o_dram_wr    = wr_q;
  assign o_dram_addr  = addr_q;
  assign o_dram_wdata = wdata_q;
  assign o_dram_ctrl  = ctrl_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: a fixed-priority instance with a
// scoreboard of expected transactions, plus a round-robin instance.
module tb_dram_port_arbiter;

`ifdef DRAM_ARB_WATCHDOG_EN
  localparam int unsigned WD = 16;
`else
  localparam int unsigned WD = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [2:0]  req, we, ack, gnt;
  logic [95:0] addr, wdata;
  logic [8:0]  ctrl;
  logic [31:0] rdata, daddr, dwdata, drdata;
  logic [2:0]  dctrl;
  logic        err, drd, dwr, busy;

  logic [2:0]  r_req, r_ack, r_gnt;
  logic [31:0] r_rdata, r_daddr, r_dwdata, r_drdata;
  logic [2:0]  r_dctrl;
  logic        r_err, r_drd, r_dwr, r_busy;
  int unsigned r_bcnt;

  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          pulses = 0;
  int          tot_pulses = 0;
  int unsigned blen = 2;
  int unsigned bcnt;
  logic        stuck = 1'b0;
  logic [31:0] rd_val = '0;

  always #5 clk = ~clk;

  dram_port_arbiter #(.NREQ(3), .RR_EN_DEFAULT(0), .WD_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .i_init_done(init_done), .i_req(req), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .i_ctrl(ctrl), .o_ack(ack), .o_rdata(rdata),
    .o_gnt(gnt), .o_err(err), .o_dram_rd(drd), .o_dram_wr(dwr),
    .o_dram_addr(daddr), .o_dram_wdata(dwdata), .o_dram_ctrl(dctrl),
    .i_dram_rdata(drdata), .i_dram_busy(busy)
  );

  dram_port_arbiter #(.NREQ(3), .RR_EN_DEFAULT(1), .WD_CYCLES(WD)) dut_rr (
    .clk(clk), .rst(rst), .i_init_done(1'b1), .i_req(r_req), .i_we(3'b000),
    .i_addr(96'h0), .i_wdata(96'h0), .i_ctrl(9'h0), .o_ack(r_ack), .o_rdata(r_rdata),
    .o_gnt(r_gnt), .o_err(r_err), .o_dram_rd(r_drd), .o_dram_wr(r_dwr),
    .o_dram_addr(r_daddr), .o_dram_wdata(r_dwdata), .o_dram_ctrl(r_dctrl),
    .i_dram_rdata(r_drdata), .i_dram_busy(r_busy)
  );

  // Controller model: busy for blen cycles after a command, read data valid
  // only on the first not-busy cycle; 'stuck' freezes busy high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; bcnt <= 0; drdata <= '0;
    end else if (drd || dwr) begin
      busy <= 1'b1; bcnt <= blen; drdata <= '0;
    end else if (stuck) begin
      drdata <= '0;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1; drdata <= '0;
    end else if (bcnt == 1) begin
      busy <= 1'b0; bcnt <= 0; drdata <= rd_val;
    end else begin
      drdata <= '0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0; r_bcnt <= 0; r_drdata <= '0;
    end else if (r_drd || r_dwr) begin
      r_busy <= 1'b1; r_bcnt <= 2;
    end else if (r_bcnt > 1) begin
      r_bcnt <= r_bcnt - 1;
    end else if (r_bcnt == 1) begin
      r_busy <= 1'b0; r_bcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every command and every ack is matched to the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (drd || dwr) begin
        pulses++;
        tot_pulses++;
        if (exp_q.size() == 0) begin
          chk("spurious_cmd", 32'(1), 32'(0));
        end else begin
          e = exp_q[0];
          chk("cmd_kind", 32'({drd, dwr}), e.we ? 32'(2'b01) : 32'(2'b10));
          chk("cmd_addr", daddr, e.addr);
          chk("cmd_ctrl", 32'(dctrl), 32'(e.ctrl));
          chk("cmd_gnt", 32'(gnt), 32'(3'b001) << e.idx);
          if (e.we) chk("cmd_wdata", dwdata, e.wdata);
        end
      end
      if (ack != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", 32'(ack), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(3'b001) << e.idx);
          if (!e.we) chk("ack_rdata", rdata, e.rdata);
          chk("cmd_pulses", 32'(pulses), 32'(1));
          pulses = 0;
        end
      end
    end
  end

  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] c, input logic [31:0] rv);
    exp_t e;
    e.idx = k; e.we = w; e.addr = a; e.wdata = d; e.ctrl = c; e.rdata = rv;
    exp_q.push_back(e);
    if (!w) rd_val = rv;
    we[k] = w;
    addr[k*32 +: 32]  = a;
    wdata[k*32 +: 32] = d;
    ctrl[k*3 +: 3]    = c;
    req[k] = 1'b1;
  endtask

  task automatic wait_ack(input int k, input bit clr);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (ack[k]) seen = 1'b1;
    end
    if (clr) req[k] = 1'b0;
    chk($sformatf("ack_arrived_%0d", k), 32'(seen), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    bit seen;
    logic [2:0] rr_exp;
    rst = 1'b1; init_done = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; ctrl = '0; r_req = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_cmd", 32'({drd, dwr}), 32'(0));
    chk("rst_addr", daddr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single read from requester 1, six busy cycles.
    blen = 6;
    issue(1, 1'b0, 32'h100, 32'h0, 3'd2, 32'h1234_5678);
    wait_ack(1, 1'b1);

    // Simultaneous writes: requester 0 before requester 2.
    blen = 3;
    issue(0, 1'b1, 32'h200, 32'hA, 3'd2, 32'h0);
    issue(2, 1'b1, 32'h300, 32'hB, 3'd1, 32'h0);
    wait_ack(0, 1'b1);
    wait_ack(2, 1'b1);

    // Fixed priority, back-to-back: held req1 starves req2 until released.
    blen = 2;
    issue(1, 1'b0, 32'h600, 32'h0, 3'd2, 32'h0606_0606);
    issue(1, 1'b0, 32'h600, 32'h0, 3'd2, 32'h0606_0606);
    issue(2, 1'b0, 32'h700, 32'h0, 3'd2, 32'h0606_0606);
    wait_ack(1, 1'b0);
    wait_ack(1, 1'b1);
    wait_ack(2, 1'b1);

    // No grant before calibration; grant on the cycle after it completes.
    init_done = 1'b0;
    snap = tot_pulses;
    issue(1, 1'b0, 32'h403, 32'h0, 3'b101, 32'hCAFE_F00D);
    repeat (5) @(negedge clk);
    chk("noinit_gnt", 32'(gnt), 32'(0));
    chk("noinit_cmds", 32'(tot_pulses), 32'(snap));
    init_done = 1'b1;
    @(negedge clk);
    chk("init_gnt", 32'(gnt), 32'(3'b010));
    chk("init_rd", 32'(drd), 32'(1));
    wait_ack(1, 1'b1);

    // Calibration drop mid-transaction: finish it, then hold off new grants.
    blen = 4;
    issue(1, 1'b0, 32'h404, 32'h0, 3'd0, 32'h55AA_55AA);
    repeat (3) @(negedge clk);
    init_done = 1'b0;
    issue(0, 1'b1, 32'h10, 32'h77, 3'd2, 32'h0);
    wait_ack(1, 1'b1);
    repeat (4) @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'(0));
    chk("drop_pending", 32'(exp_q.size()), 32'(1));
    init_done = 1'b1;
    wait_ack(0, 1'b1);

    // Round-robin instance: continuous req1/req2 alternate starting at 1.
    r_req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (r_ack != 3'b000) seen = 1'b1;
      end
      rr_exp = (i % 2 == 0) ? 3'b010 : 3'b100;
      chk($sformatf("rr_ack_%0d", i), 32'(r_ack), 32'(rr_exp));
    end
    r_req = '0;

    // Asynchronous reset in WAIT_DONE clears every output immediately.
    blen = 10;
    issue(1, 1'b0, 32'h800, 32'h0, 3'd2, 32'h8888_8888);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(0));
    chk("arst_cmd", 32'({drd, dwr}), 32'(0));
    chk("arst_addr", daddr, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    exp_q.delete();
    pulses = 0;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    blen = 3;
    issue(2, 1'b0, 32'h900, 32'h0, 3'd2, 32'h0BAD_F00D);
    wait_ack(2, 1'b1);

`ifdef DRAM_ARB_WATCHDOG_EN
    // Controller stuck busy: watchdog acks with the poison value.
    stuck = 1'b1;
    chk("wd_err_before", 32'(err), 32'(0));
    issue(1, 1'b0, 32'hA00, 32'h0, 3'd2, 32'hDEAD_BEEF);
    wait_ack(1, 1'b1);
    chk("wd_err", 32'(err), 32'(1));
    stuck = 1'b0;
    repeat (6) @(negedge clk);
    chk("wd_err_sticky", 32'(err), 32'(1));
`else
    chk("no_wd_err", 32'(err), 32'(0));
`endif

    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
